// File: rtl/pipeline_ctrl_if.sv
// Pipeline-side signal bundle for the hazard/sequencing controller.
// The pipeline is the master: it drives stage observations and consumes the controls.
interface pipeline_ctrl_if #(
   parameter int unsigned CNT_W = 32
);
   logic [4:0]       id_rs_i;
   logic [4:0]       id_rt_i;
   logic             id_use_rs_i;
   logic             id_use_rt_i;
   logic             ex_memtoreg_i;
   logic [4:0]       ex_rd_i;
   logic             mem_branch_i;
   logic             mem_zero_i;
   logic             mem_jump_i;
   logic             mem_memtoreg_i;
   logic             mem_memwrite_i;
   logic             dmem_ready_i;

   logic             pc_write_o;
   logic             pc_sel_o;
   logic             ifid_write_o;
   logic             idex_write_o;
   logic             exmem_write_o;
   logic             ifid_flush_o;
   logic             idex_flush_o;
   logic             exmem_flush_o;
   logic             memwb_flush_o;
   logic             dmem_req_o;
   logic [1:0]       state_o;
   logic [CNT_W-1:0] stall_cnt_o;
   logic             timeout_o;

   modport master (
      output id_rs_i, id_rt_i, id_use_rs_i, id_use_rt_i, ex_memtoreg_i, ex_rd_i,
             mem_branch_i, mem_zero_i, mem_jump_i, mem_memtoreg_i, mem_memwrite_i,
             dmem_ready_i,
      input  pc_write_o, pc_sel_o, ifid_write_o, idex_write_o, exmem_write_o,
             ifid_flush_o, idex_flush_o, exmem_flush_o, memwb_flush_o, dmem_req_o,
             state_o, stall_cnt_o, timeout_o
   );

   modport slave (
      input  id_rs_i, id_rt_i, id_use_rs_i, id_use_rt_i, ex_memtoreg_i, ex_rd_i,
             mem_branch_i, mem_zero_i, mem_jump_i, mem_memtoreg_i, mem_memwrite_i,
             dmem_ready_i,
      output pc_write_o, pc_sel_o, ifid_write_o, idex_write_o, exmem_write_o,
             ifid_flush_o, idex_flush_o, exmem_flush_o, memwb_flush_o, dmem_req_o,
             state_o, stall_cnt_o, timeout_o
   );
endinterface

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: load-use stalls,
// EX/MEM redirects, data-memory waits with timeout, and a saturating stall counter.
module pipeline_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned CNT_W       = 32
) (
   input  logic           clk_i,
   input  logic           rst_i,
   pipeline_ctrl_if.slave bus
);
   localparam int unsigned         WCNT_W    = 8;
   localparam logic [WCNT_W-1:0]   WCNT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      HALT     = 2'd2
   } state_t;

   state_t             state, state_nxt;
   logic [WCNT_W-1:0]  wait_cnt, wait_cnt_nxt;
   logic [CNT_W-1:0]   stall_cnt;
   logic               timeout, set_timeout;

   logic acc, take, lu, mem_wait;
   logic freeze, resolve;
   logic pc_write, pc_sel, ifid_write, idex_write, exmem_write;
   logic ifid_flush, idex_flush, exmem_flush, memwb_flush, dmem_req;

   assign acc      = bus.mem_memtoreg_i | bus.mem_memwrite_i;
   assign take     = (bus.mem_branch_i & bus.mem_zero_i) | bus.mem_jump_i;
   assign lu       = bus.ex_memtoreg_i & (bus.ex_rd_i != 5'd0) &
                     ((bus.id_use_rs_i & (bus.id_rs_i == bus.ex_rd_i)) |
                      (bus.id_use_rt_i & (bus.id_rt_i == bus.ex_rd_i)));
   assign mem_wait = acc & ~bus.dmem_ready_i;

   // State, wait counter, sticky timeout and saturating stall counter.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state     <= RUN;
         wait_cnt  <= '0;
         stall_cnt <= '0;
         timeout   <= 1'b0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
         timeout  <= timeout | set_timeout;
         if ((state != HALT) && !pc_write && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

   // Next state and stage controls; wait beats redirect beats load-use.
   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      set_timeout  = 1'b0;
      freeze       = 1'b0;
      resolve      = 1'b0;
      pc_write     = 1'b1;
      pc_sel       = 1'b0;
      ifid_write   = 1'b1;
      idex_write   = 1'b1;
      exmem_write  = 1'b1;
      ifid_flush   = 1'b0;
      idex_flush   = 1'b0;
      exmem_flush  = 1'b0;
      memwb_flush  = 1'b0;
      dmem_req     = acc;

      case (state)
         RUN: begin
            if (mem_wait) begin
               freeze       = 1'b1;
               state_nxt    = MEM_WAIT;
               wait_cnt_nxt = WCNT_W'(1);
            end else begin
               resolve = 1'b1;
            end
         end
         MEM_WAIT: begin
            if (bus.dmem_ready_i) begin
               resolve      = 1'b1;
               state_nxt    = RUN;
               wait_cnt_nxt = '0;
            end else if (wait_cnt == WCNT_LAST) begin
               freeze      = 1'b1;
               state_nxt   = HALT;
               set_timeout = 1'b1;
            end else begin
               freeze       = 1'b1;
               wait_cnt_nxt = wait_cnt + WCNT_W'(1);
            end
         end
         HALT: begin
            freeze   = 1'b1;
            dmem_req = 1'b0;
         end
         default: state_nxt = RUN;
      endcase

      if (freeze) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         idex_write  = 1'b0;
         exmem_write = 1'b0;
         memwb_flush = 1'b1;
      end

      // A redirect flushes IF/ID, which also squashes any load-use consumer.
      if (resolve) begin
         if (take) begin
            pc_sel      = 1'b1;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
         end else if (lu) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
         end
      end

      if (!rst_i) begin
         pc_write    = 1'b0;
         pc_sel      = 1'b0;
         ifid_write  = 1'b0;
         idex_write  = 1'b0;
         exmem_write = 1'b0;
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
         exmem_flush = 1'b1;
         memwb_flush = 1'b1;
         dmem_req    = 1'b0;
      end
   end

   assign bus.pc_write_o    = pc_write;
   assign bus.pc_sel_o      = pc_sel;
   assign bus.ifid_write_o  = ifid_write;
   assign bus.idex_write_o  = idex_write;
   assign bus.exmem_write_o = exmem_write;
   assign bus.ifid_flush_o  = ifid_flush;
   assign bus.idex_flush_o  = idex_flush;
   assign bus.exmem_flush_o = exmem_flush;
   assign bus.memwb_flush_o = memwb_flush;
   assign bus.dmem_req_o    = dmem_req;
   assign bus.state_o       = state;
   assign bus.stall_cnt_o   = stall_cnt;
   assign bus.timeout_o     = timeout;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl with MEM_TIMEOUT=4 and a 4-bit stall counter.
module tb_pipeline_ctrl;
   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;

   pipeline_ctrl_if #(.CNT_W(4)) bus ();

   pipeline_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_inputs();
      bus.id_rs_i        = 5'd0;
      bus.id_rt_i        = 5'd0;
      bus.id_use_rs_i    = 1'b0;
      bus.id_use_rt_i    = 1'b0;
      bus.ex_memtoreg_i  = 1'b0;
      bus.ex_rd_i        = 5'd0;
      bus.mem_branch_i   = 1'b0;
      bus.mem_zero_i     = 1'b0;
      bus.mem_jump_i     = 1'b0;
      bus.mem_memtoreg_i = 1'b0;
      bus.mem_memwrite_i = 1'b0;
      bus.dmem_ready_i   = 1'b1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      clear_inputs();
      tick();
      rst = 1'b1;
   endtask

   task automatic set_lu();
      bus.ex_memtoreg_i = 1'b1;
      bus.ex_rd_i       = 5'd8;
      bus.id_rs_i       = 5'd8;
      bus.id_use_rs_i   = 1'b1;
   endtask

   task automatic check_forced(input string tag);
      check({tag, "_pcw"},  32'(bus.pc_write_o),    32'd0);
      check({tag, "_psel"}, 32'(bus.pc_sel_o),      32'd0);
      check({tag, "_exw"},  32'(bus.exmem_write_o), 32'd0);
      check({tag, "_iff"},  32'(bus.ifid_flush_o),  32'd1);
      check({tag, "_mwf"},  32'(bus.memwb_flush_o), 32'd1);
      check({tag, "_req"},  32'(bus.dmem_req_o),    32'd0);
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;

      // Reset forces outputs even with active requests on the inputs.
      rst = 1'b0;
      clear_inputs();
      bus.mem_memtoreg_i = 1'b1;
      bus.mem_branch_i   = 1'b1;
      bus.mem_zero_i     = 1'b1;
      #1;
      check_forced("rst");
      tick();
      check("rst_state", 32'(bus.state_o),     32'd0);
      check("rst_cnt",   32'(bus.stall_cnt_o), 32'd0);
      check("rst_to",    32'(bus.timeout_o),   32'd0);
      clear_inputs();
      rst = 1'b1;

      // Load-use: one bubble, counter 0 -> 1.
      set_lu();
      #1;
      check("lu_pcw",  32'(bus.pc_write_o),    32'd0);
      check("lu_ifw",  32'(bus.ifid_write_o),  32'd0);
      check("lu_idf",  32'(bus.idex_flush_o),  32'd1);
      check("lu_idw",  32'(bus.idex_write_o),  32'd1);
      check("lu_mwf",  32'(bus.memwb_flush_o), 32'd0);
      tick();
      check("lu_cnt",  32'(bus.stall_cnt_o),   32'd1);
      bus.ex_rd_i = 5'd0;
      bus.id_rs_i = 5'd0;
      #1;
      check("lu_r0_pcw", 32'(bus.pc_write_o),   32'd1);
      check("lu_r0_idf", 32'(bus.idex_flush_o), 32'd0);
      tick();
      check("lu_r0_cnt", 32'(bus.stall_cnt_o),  32'd1);
      // rt match stalls; rs match without use does not.
      clear_inputs();
      bus.ex_memtoreg_i = 1'b1;
      bus.ex_rd_i       = 5'd5;
      bus.id_rt_i       = 5'd5;
      bus.id_use_rt_i   = 1'b1;
      #1;
      check("lu_rt_pcw", 32'(bus.pc_write_o), 32'd0);
      bus.id_use_rt_i = 1'b0;
      bus.id_rs_i     = 5'd5;
      #1;
      check("lu_nouse_pcw", 32'(bus.pc_write_o), 32'd1);
      clear_inputs();

      // Branch taken / not taken, and jump.
      bus.mem_branch_i = 1'b1;
      bus.mem_zero_i   = 1'b1;
      #1;
      check("br_psel", 32'(bus.pc_sel_o),      32'd1);
      check("br_pcw",  32'(bus.pc_write_o),    32'd1);
      check("br_iff",  32'(bus.ifid_flush_o),  32'd1);
      check("br_idf",  32'(bus.idex_flush_o),  32'd1);
      check("br_exf",  32'(bus.exmem_flush_o), 32'd1);
      check("br_mwf",  32'(bus.memwb_flush_o), 32'd0);
      bus.mem_zero_i = 1'b0;
      #1;
      check("bnt_psel", 32'(bus.pc_sel_o),     32'd0);
      check("bnt_iff",  32'(bus.ifid_flush_o), 32'd0);
      bus.mem_branch_i = 1'b0;
      bus.mem_jump_i   = 1'b1;
      #1;
      check("jmp_psel", 32'(bus.pc_sel_o), 32'd1);
      clear_inputs();

      // Memory wait: 3 frozen cycles then ready.
      do_reset();
      bus.mem_memtoreg_i = 1'b1;
      bus.dmem_ready_i   = 1'b0;
      #1;
      check("mw0_state", 32'(bus.state_o),       32'd0);
      check("mw0_req",   32'(bus.dmem_req_o),    32'd1);
      check("mw0_pcw",   32'(bus.pc_write_o),    32'd0);
      check("mw0_exw",   32'(bus.exmem_write_o), 32'd0);
      check("mw0_mwf",   32'(bus.memwb_flush_o), 32'd1);
      for (int i = 1; i <= 2; i++) begin
         tick();
         check($sformatf("mw%0d_state", i), 32'(bus.state_o),       32'd1);
         check($sformatf("mw%0d_mwf", i),   32'(bus.memwb_flush_o), 32'd1);
      end
      tick();
      bus.dmem_ready_i = 1'b1;
      #1;
      check("mw3_state", 32'(bus.state_o),       32'd1);
      check("mw3_pcw",   32'(bus.pc_write_o),    32'd1);
      check("mw3_mwf",   32'(bus.memwb_flush_o), 32'd0);
      tick();
      check("mw_end_state", 32'(bus.state_o),     32'd0);
      check("mw_end_cnt",   32'(bus.stall_cnt_o), 32'd3);
      clear_inputs();

      // Wait + take + load-use together: freeze only; on ready, redirect wins.
      do_reset();
      set_lu();
      bus.mem_branch_i   = 1'b1;
      bus.mem_zero_i     = 1'b1;
      bus.mem_memtoreg_i = 1'b1;
      bus.dmem_ready_i   = 1'b0;
      #1;
      check("sim_psel", 32'(bus.pc_sel_o),      32'd0);
      check("sim_pcw",  32'(bus.pc_write_o),    32'd0);
      check("sim_idf",  32'(bus.idex_flush_o),  32'd0);
      check("sim_mwf",  32'(bus.memwb_flush_o), 32'd1);
      tick();
      bus.dmem_ready_i = 1'b1;
      #1;
      check("simr_psel", 32'(bus.pc_sel_o),     32'd1);
      check("simr_pcw",  32'(bus.pc_write_o),   32'd1);
      check("simr_ifw",  32'(bus.ifid_write_o), 32'd1);
      check("simr_iff",  32'(bus.ifid_flush_o), 32'd1);
      tick();
      check("simr_state", 32'(bus.state_o),     32'd0);
      check("simr_cnt",   32'(bus.stall_cnt_o), 32'd1);
      clear_inputs();

      // Timeout: 4 consecutive not-ready cycles reach HALT.
      do_reset();
      bus.mem_memtoreg_i = 1'b1;
      bus.dmem_ready_i   = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         tick();
         check($sformatf("to%0d_state", i), 32'(bus.state_o),   32'd1);
         check($sformatf("to%0d_flag", i),  32'(bus.timeout_o), 32'd0);
      end
      tick();
      check("to_state", 32'(bus.state_o),     32'd2);
      check("to_flag",  32'(bus.timeout_o),   32'd1);
      check("to_req",   32'(bus.dmem_req_o),  32'd0);
      check("to_pcw",   32'(bus.pc_write_o),  32'd0);
      check("to_cnt",   32'(bus.stall_cnt_o), 32'd4);
      bus.dmem_ready_i = 1'b1;
      tick();
      check("halt_hold_state", 32'(bus.state_o),     32'd2);
      check("halt_hold_cnt",   32'(bus.stall_cnt_o), 32'd4);
      check("halt_hold_flag",  32'(bus.timeout_o),   32'd1);
      rst = 1'b0;
      #1;
      check_forced("halt_rst");
      tick();
      check("halt_rst_state", 32'(bus.state_o),     32'd0);
      check("halt_rst_flag",  32'(bus.timeout_o),   32'd0);
      check("halt_rst_cnt",   32'(bus.stall_cnt_o), 32'd0);
      rst = 1'b1;
      clear_inputs();

      // Saturation: 20 load-use stalls on a 4-bit counter stop at 15.
      do_reset();
      set_lu();
      for (int i = 0; i < 15; i++) tick();
      check("sat15_cnt", 32'(bus.stall_cnt_o), 32'd15);
      for (int i = 0; i < 5; i++) tick();
      check("sat20_cnt", 32'(bus.stall_cnt_o), 32'd15);
      clear_inputs();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
